// File: rtl/aes_pkg.sv
// Shared AES definitions: field polynomial, FSM state names, byte-select type
// and the forward S-box / MixColumn-byte / rotate helpers used by the column units.
package aes_pkg;

    localparam logic [8:0] GF_POLY = 9'h11B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [1:0] bsel_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as x^254 (x^2 * x^4 * ... * x^128), which maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_fwd_byte(input logic [7:0] so);
        return {xtime(so) ^ so, so, so, xtime(so)};
    endfunction

    function automatic logic [31:0] rol32_bytes(input logic [31:0] x, input bsel_t bs);
        logic [31:0] r;
        case (bs)
            2'd0:    r = x;
            2'd1:    r = {x[23:0], x[31:24]};
            2'd2:    r = {x[15:0], x[31:16]};
            default: r = {x[7:0],  x[31:8]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes32esmi_iter_if.sv
// Request/response bundle of the iterative middle-round column unit.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface aes32esmi_iter_if;
    import aes_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic        in_chain;
    bsel_t       in_bs;
    logic [31:0] in_rs1;
    logic [31:0] in_src0;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [31:0] in_src3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd;

    modport master (
        output in_valid, in_chain, in_bs, in_rs1, in_src0, in_src1, in_src2, in_src3, out_ready,
        input  in_ready, out_valid, out_rd
    );

    modport slave (
        input  in_valid, in_chain, in_bs, in_rs1, in_src0, in_src1, in_src2, in_src3, out_ready,
        output in_ready, out_valid, out_rd
    );

endinterface

// File: rtl/aes32esmi.sv
// Combinational forward middle-round byte step:
// rd = rotl32(MixColumnByte(SBox(rs2 byte bs)), 8*bs) ^ rs1.
module aes32esmi
    import aes_pkg::*;
(
    input  bsel_t       bs,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd
);

    logic [31:0] shifted;
    logic [7:0]  si;
    logic [7:0]  so;
    logic [31:0] mixed;

    always_comb begin
        shifted = rs2 >> {bs, 3'b000};
        si      = shifted[7:0];
        so      = sbox_fwd(si);
        mixed   = mix_fwd_byte(so);
        rd      = rol32_bytes(mixed, bs) ^ rs1;
    end

endmodule

// File: rtl/aes32esmi_iter.sv
// Iterative wrapper: captures one request, runs one or CHAIN_STEPS byte steps through
// a single shared aes32esmi datapath, then holds the result until it is taken.
module aes32esmi_iter
    import aes_pkg::*;
#(
    parameter int CHAIN_STEPS = 4
) (
    input  logic            clk,
    input  logic            rst,
    aes32esmi_iter_if.slave bus,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_BUSY   = BUSY;
    localparam logic [1:0] ST_DONE   = DONE;
    localparam logic [1:0] LAST_STEP = 2'(CHAIN_STEPS - 1);

    logic [1:0]  state;
    logic [1:0]  step;
    logic        chain_q;
    bsel_t       bs_q;
    logic [31:0] acc;
    logic [31:0] src_q [4];
    bsel_t       cur_bs;
    logic [31:0] cur_src;
    logic [31:0] nxt_acc;
    logic        last_step;

    // Chain mode walks byte selects 0..CHAIN_STEPS-1 with a fresh source word per step.
    always_comb begin
        cur_bs    = chain_q ? step : bs_q;
        cur_src   = chain_q ? src_q[step] : src_q[0];
        last_step = !chain_q || (step == LAST_STEP);
    end

    aes32esmi u_esmi (
        .bs  (cur_bs),
        .rs1 (acc),
        .rs2 (cur_src),
        .rd  (nxt_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            step     <= 2'd0;
            chain_q  <= 1'b0;
            bs_q     <= 2'd0;
            acc      <= 32'h0;
            src_q[0] <= 32'h0;
            src_q[1] <= 32'h0;
            src_q[2] <= 32'h0;
            src_q[3] <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        acc      <= bus.in_rs1;
                        src_q[0] <= bus.in_src0;
                        src_q[1] <= bus.in_src1;
                        src_q[2] <= bus.in_src2;
                        src_q[3] <= bus.in_src3;
                        bs_q     <= bus.in_bs;
                        chain_q  <= bus.in_chain;
                        step     <= 2'd0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc  <= nxt_acc;
                    step <= step + 2'd1;
                    if (last_step) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_rd    = acc;
    assign dbg_state     = state;

endmodule

// File: tb/tb_aes32esmi_iter.sv
// Scoreboard bench for aes32esmi_iter: directed anchors, backpressure, mid-chain reset
// and randomized traffic checked against a field-arithmetic reference model.
module tb_aes32esmi_iter;

    localparam int CHAIN_STEPS = 4;
    localparam int N_RAND      = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dbg_state;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          sent  = 0;
    int          got   = 0;
    int          rdy_mode = 0;
    logic [7:0]  sbox_t [256];
    logic [31:0] exp_q [$];
    int          lat_q [$];
    int          acc_q [$];

    aes32esmi_iter_if bus ();

    aes32esmi_iter #(.CHAIN_STEPS(CHAIN_STEPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [15:0] poly;
        p    = 16'h0;
        poly = 16'h011B;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (poly << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] m_esmi(input int bs, input logic [31:0] acc,
                                           input logic [31:0] src);
        logic [7:0]  so;
        logic [31:0] mixed;
        logic [63:0] dbl;
        so    = sbox_t[(src >> (8 * bs)) & 32'hFF];
        mixed = {m_mul(so, 8'h03), so, so, m_mul(so, 8'h02)};
        dbl   = {mixed, mixed} << (8 * bs);
        return dbl[63:32] ^ acc;
    endfunction

    function automatic logic [31:0] m_txn(input logic ch, input logic [1:0] bs,
                                          input logic [31:0] rs1, input logic [3:0][31:0] s);
        logic [31:0] a;
        a = rs1;
        if (ch) for (int k = 0; k < CHAIN_STEPS; k++) a = m_esmi(k, a, s[k]);
        else    a = m_esmi(int'(bs), a, s[0]);
        return a;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic ch, input logic [1:0] bs, input logic [31:0] rs1,
                        input logic [3:0][31:0] s, input logic [31:0] exp);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_chain = ch;
        bus.in_bs    = bs;
        bus.in_rs1   = rs1;
        bus.in_src0  = s[0];
        bus.in_src1  = s[1];
        bus.in_src2  = s[2];
        bus.in_src3  = s[3];
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout: in_ready=%0b want 1 within 200 cycles", bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(exp);
        lat_q.push_back(ch ? CHAIN_STEPS + 1 : 2);
        acc_q.push_back(cyc);
        sent++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_rs1   = $urandom;
        bus.in_src0  = $urandom;
        bus.in_src1  = $urandom;
        bus.in_src2  = $urandom;
        bus.in_src3  = $urandom;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        held;
        logic [31:0] hexp;
        int          lat;
        int          acyc;
        held = 1'b0;
        hexp = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (bus.out_valid) begin
                if (!held) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL spurious_result: out_rd=%h with no request outstanding", bus.out_rd);
                    end else begin
                        hexp = exp_q.pop_front();
                        lat  = lat_q.pop_front();
                        acyc = acc_q.pop_front();
                        got++;
                        total++;
                        if (bus.out_rd !== hexp) begin
                            bad++;
                            $display("FAIL result: out_rd=%h want %h", bus.out_rd, hexp);
                        end
                        total++;
                        if (cyc - acyc != lat) begin
                            bad++;
                            $display("FAIL latency: got %0d cycles want %0d", cyc - acyc, lat);
                        end
                    end
                    held = 1'b1;
                end else begin
                    total++;
                    if (bus.out_rd !== hexp || bus.in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL hold_stable: out_rd=%h in_ready=%0b want %h and 0",
                                 bus.out_rd, bus.in_ready, hexp);
                    end
                end
                if (bus.out_ready) held = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, sent=%0d got=%0d", sent, got);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0][31:0] s;
        logic             ch;
        logic [1:0]       bs;
        logic [31:0]      rs1;
        int               w;

        for (int i = 0; i < 256; i++) sbox_t[i] = m_sbox_calc(8'(i));

        bus.in_valid = 1'b0;
        bus.in_chain = 1'b0;
        bus.in_bs    = 2'd0;
        bus.in_rs1   = 32'h0;
        bus.in_src0  = 32'h0;
        bus.in_src1  = 32'h0;
        bus.in_src2  = 32'h0;
        bus.in_src3  = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_rd !== 32'h0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_values: in_ready=%0b out_valid=%0b out_rd=%h state=%0d want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_rd, dbg_state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // directed anchors
        rdy_mode = 0;
        s = '0;
        send(1'b0, 2'd0, 32'h0, s, 32'hA56363C6);
        s[0] = 32'h00000100;
        send(1'b0, 2'd1, 32'h0, s, 32'h7C7CF884);
        s = '0;
        send(1'b1, 2'd3, 32'h0, s, 32'h63636363);
        send(1'b1, 2'd1, 32'hFFFFFFFF, s, 32'h9C9C9C9C);
        s = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00AB0000};
        send(1'b0, 2'd2, 32'h12345678, s, m_txn(1'b0, 2'd2, 32'h12345678, s));
        s = {32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h53535353};
        send(1'b0, 2'd3, 32'h0, s, m_txn(1'b0, 2'd3, 32'h0, s));
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);

        // backpressure: result held, new requests ignored, then released
        rdy_mode = 2;
        @(posedge clk);
        #1;
        s = '0;
        send(1'b0, 2'd0, 32'h0, s, 32'hA56363C6);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (!bus.out_valid) begin
            bad++;
            $display("FAIL bp_wait_valid: out_valid=%0b want 1 within 50 cycles", bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.in_chain = 1'b1;
        bus.in_rs1   = 32'h5A5A5A5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold: in_ready=%0b out_valid=%0b want 0 1", bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1 0", bus.in_ready, bus.out_valid);
        end

        // reset in the middle of a chain
        @(posedge clk);
        #1;
        s = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send(1'b1, 2'd0, 32'hCAFEF00D, s, m_txn(1'b1, 2'd0, 32'hCAFEF00D, s));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || dbg_state !== 2'd0 || bus.out_rd !== 32'h0) begin
            bad++;
            $display("FAIL midchain_reset: in_ready=%0b out_valid=%0b state=%0d out_rd=%h want 1 0 0 0",
                     bus.in_ready, bus.out_valid, dbg_state, bus.out_rd);
        end
        sent = sent - exp_q.size();
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        s = '0;
        send(1'b1, 2'd0, 32'h0, s, 32'h63636363);
        s = {32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};
        send(1'b1, 2'd2, 32'h0BADCAFE, s, m_txn(1'b1, 2'd2, 32'h0BADCAFE, s));

        // randomized traffic with consumer stalls
        rdy_mode = 1;
        for (int n = 0; n < N_RAND; n++) begin
            ch  = 1'($urandom);
            bs  = 2'($urandom);
            rs1 = $urandom;
            for (int k = 0; k < 4; k++) s[k] = $urandom;
            w = $urandom_range(0, 2);
            repeat (w) @(posedge clk);
            #1;
            send(ch, bs, rs1, s, m_txn(ch, bs, rs1, s));
        end

        rdy_mode = 0;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0 || got != sent) begin
            bad++;
            $display("FAIL drain: outstanding=%0d got=%0d want 0 and %0d", exp_q.size(), got, sent);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
